// File: rtl/bcd_updown_counter_7seg_if.sv
// Control inputs and display/status outputs of the BCD up/down counter.
// master drives the controls; slave is the counter itself.
interface bcd_updown_counter_7seg_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;
  logic                  wrap;
  logic                  load_err;
  logic                  at_max;
  logic                  at_min;

  modport master (
    output en, up, load, load_val,
    input  bcd, seg, wrap, load_err, at_max, at_min
  );

  modport slave (
    input  en, up, load, load_val,
    output bcd, seg, wrap, load_err, at_max, at_min
  );
endinterface

// File: rtl/bcd_updown_counter_7seg.sv
// N-digit BCD up/down counter with load, wrap/saturate ends and direct
// active-low 7-segment outputs; every output is registered.
module bcd_updown_counter_7seg #(
  parameter int unsigned DIGITS        = 2,
  parameter int unsigned MAX_VALUE     = 99,
  parameter bit          SATURATE      = 1'b0,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  bcd_updown_counter_7seg_if.slave bus
);
  localparam int unsigned W  = 4*DIGITS;
  localparam int unsigned SW = 7*DIGITS;

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Scan from the top digit down; blanking stops at the first nonzero digit.
  function automatic logic [SW-1:0] seg_encode(input logic [W-1:0] v);
    logic [SW-1:0] s;
    logic          lead;
    s    = '1;
    lead = 1'b1;
    for (int unsigned k = DIGITS-1; k > 0; k--) begin
      if (BLANK_LEADING && lead && (v[4*k +: 4] == 4'd0)) begin
        s[7*k +: 7] = 7'b1111111;
      end else begin
        lead        = 1'b0;
        s[7*k +: 7] = seg_digit(v[4*k +: 4]);
      end
    end
    s[6:0] = seg_digit(v[3:0]);
    return s;
  endfunction

  function automatic logic bcd_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0]  MAX_BCD  = to_bcd(MAX_VALUE);
  localparam logic [SW-1:0] SEG_ZERO = seg_encode('0);

  logic [W-1:0]  cnt_q, nxt;
  logic [SW-1:0] seg_q;
  logic          wrap_q, err_q, max_q, min_q;
  logic          nxt_wrap, nxt_err;

  // Valid BCD compares correctly as plain unsigned, so range checks need no conversion.
  always_comb begin
    nxt      = cnt_q;
    nxt_wrap = 1'b0;
    nxt_err  = 1'b0;
    if (bus.load) begin
      if (bcd_ok(bus.load_val) && (bus.load_val <= MAX_BCD)) nxt = bus.load_val;
      else                                                   nxt_err = 1'b1;
    end else if (bus.en) begin
      if (bus.up) begin
        if (cnt_q == MAX_BCD) begin
          if (!SATURATE) begin
            nxt      = '0;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt = bcd_inc(cnt_q);
        end
      end else begin
        if (cnt_q == '0) begin
          if (!SATURATE) begin
            nxt      = MAX_BCD;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt = bcd_dec(cnt_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      seg_q  <= SEG_ZERO;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      max_q  <= (MAX_VALUE == 0);
      min_q  <= 1'b1;
    end else begin
      cnt_q  <= nxt;
      seg_q  <= seg_encode(nxt);
      wrap_q <= nxt_wrap;
      err_q  <= nxt_err;
      max_q  <= (nxt == MAX_BCD);
      min_q  <= (nxt == '0);
    end
  end

  assign bus.bcd      = cnt_q;
  assign bus.seg      = seg_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
  assign bus.at_max   = max_q;
  assign bus.at_min   = min_q;
endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
// Directed, table-driven bench for bcd_updown_counter_7seg: a wrapping
// 0..99 instance with blanking and a saturating 0..42 instance without.
module tb_bcd_updown_counter_7seg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_updown_counter_7seg_if #(.DIGITS(2)) wif ();
  bcd_updown_counter_7seg_if #(.DIGITS(2)) sif ();

  bcd_updown_counter_7seg #(
    .DIGITS(2), .MAX_VALUE(99), .SATURATE(1'b0), .BLANK_LEADING(1'b1)
  ) dut_w (
    .clk(clk), .rst(rst), .bus(wif)
  );

  bcd_updown_counter_7seg #(
    .DIGITS(2), .MAX_VALUE(42), .SATURATE(1'b1), .BLANK_LEADING(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .bus(sif)
  );

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] lv;
    logic [7:0] bcd;
    logic       wrap;
    logic       err;
    logic       amax;
    logic       amin;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  function automatic logic [13:0] seg2_ref(input logic [7:0] b, input bit blank);
    logic [6:0] hi;
    hi = (blank && b[7:4] == 4'd0) ? 7'b1111111 : seg_ref(b[7:4]);
    return {hi, seg_ref(b[3:0])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w(input logic ld, input logic e, input logic u, input logic [7:0] lv);
    wif.load = ld; wif.en = e; wif.up = u; wif.load_val = lv;
  endtask

  task automatic drive_s(input logic ld, input logic e, input logic u, input logic [7:0] lv);
    sif.load = ld; sif.en = e; sif.up = u; sif.load_val = lv;
  endtask

  task automatic check_w(input string tag, input logic [7:0] b, input logic w,
                         input logic e, input logic mx, input logic mn);
    chk({tag, " bcd"},  32'(wif.bcd), 32'(b));
    chk({tag, " seg"},  32'(wif.seg), 32'(seg2_ref(b, 1'b1)));
    chk({tag, " wrap"}, 32'(wif.wrap), 32'(w));
    chk({tag, " err"},  32'(wif.load_err), 32'(e));
    chk({tag, " max"},  32'(wif.at_max), 32'(mx));
    chk({tag, " min"},  32'(wif.at_min), 32'(mn));
  endtask

  task automatic check_s(input string tag, input logic [7:0] b, input logic w,
                         input logic e, input logic mx, input logic mn);
    chk({tag, " bcd"},  32'(sif.bcd), 32'(b));
    chk({tag, " seg"},  32'(sif.seg), 32'(seg2_ref(b, 1'b0)));
    chk({tag, " wrap"}, 32'(sif.wrap), 32'(w));
    chk({tag, " err"},  32'(sif.load_err), 32'(e));
    chk({tag, " max"},  32'(sif.at_max), 32'(mx));
    chk({tag, " min"},  32'(sif.at_min), 32'(mn));
  endtask

  initial begin
    //            load  en    up    lv     bcd    wrap  err   max   min
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h3A, 8'h09, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'hA0, 8'h09, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h57, 8'h57, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h99, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h19, 8'h19, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0};

    drive_w(1'b0, 1'b0, 1'b0, 8'h00);
    drive_s(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset
    #1 rst = 1'b0;
    #1;
    chk("reset seg literal", 32'(wif.seg), 32'(14'b1111111_0000001));
    check_w("reset w", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset seg noblank", 32'(sif.seg), 32'(14'b0000001_0000001));
    check_s("reset s", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_w($sformatf("idle%0d", i), 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Up count with decimal carry
    drive_w(1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("up%0d bcd", i), 32'(wif.bcd), i);
    end
    chk("up9 seg", 32'(wif.seg), 32'(14'b1111111_0000100));
    tick();
    chk("carry bcd", 32'(wif.bcd), 32'h10);
    chk("carry seg", 32'(wif.seg), 32'(14'b1001111_0000001));

    for (int i = 0; i < 16; i++) begin
      drive_w(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
      tick();
      check_w($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].wrap, vecs[i].err,
              vecs[i].amax, vecs[i].amin);
    end
    drive_w(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_w("wrap cleared", 8'h21, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturating instance, range 0..42
    drive_s(1'b1, 1'b0, 1'b0, 8'h41);
    tick();
    check_s("sat ld41", 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_s(1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    check_s("sat up42", 8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_s($sformatf("sat hold%0d", i), 8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    drive_s(1'b1, 1'b0, 1'b0, 8'h43);
    tick();
    check_s("sat ld43 rej", 8'h42, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_s(1'b1, 1'b0, 1'b0, 8'h42);
    tick();
    check_s("sat ld42 ok", 8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_s(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check_s("sat ld00", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_s(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_s($sformatf("sat floor%0d", i), 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    drive_s(1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    check_s("sat up01", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat up01 seg literal", 32'(sif.seg), 32'(14'b0000001_1001111));
    drive_s(1'b0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset between edges
    drive_w(1'b1, 1'b0, 1'b0, 8'h37);
    tick();
    check_w("pre-rst", 8'h37, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_w(1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    check_w("async rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("async rst s", 32'(sif.bcd), 32'h00);
    #1 rst = 1'b1;
    drive_w(1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    check_w("post-rst up", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
